// File: rtl/hack_pkg.sv
// Shared constants for the Hack screen read side: memory map anchors,
// default raster timing and a sync-level helper.
package hack_pkg;

  localparam logic [15:0] SCREEN_BASE  = 16'h4000;
  localparam logic [15:0] KBD_ADDR     = 16'h6000;
  localparam int          SCREEN_WORDS = 8192;

  localparam int DEF_H_ACTIVE = 512;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 64;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 256;
  localparam int DEF_V_FRONT  = 3;
  localparam int DEF_V_SYNC   = 4;
  localparam int DEF_V_BACK   = 21;
  localparam int DEF_ADDR_W   = $clog2(SCREEN_WORDS);

  // Drive the asserted polarity inside the pulse window, the opposite level outside.
  function automatic logic syncLevel(logic inRange, logic pol);
    return inRange ? pol : ~pol;
  endfunction

endpackage

// File: rtl/hack_scan_timing.sv
// Raster position counters plus the combinational decodes derived from them:
// visibility, sync windows, frame origin and the two kinds of word fetch.
module hack_scan_timing
  import hack_pkg::*;
#(
  parameter int  H_ACTIVE = DEF_H_ACTIVE,
  parameter int  H_FRONT  = DEF_H_FRONT,
  parameter int  H_SYNC   = DEF_H_SYNC,
  parameter int  H_BACK   = DEF_H_BACK,
  parameter int  V_ACTIVE = DEF_V_ACTIVE,
  parameter int  V_FRONT  = DEF_V_FRONT,
  parameter int  V_SYNC   = DEF_V_SYNC,
  parameter int  V_BACK   = DEF_V_BACK,
  parameter bit  SYNC_POL = 1'b1,
  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
  localparam int H_W      = $clog2(H_TOTAL),
  localparam int V_W      = $clog2(V_TOTAL)
) (
  input  logic           clock,
  input  logic           reset,
  output logic [H_W-1:0] h,
  output logic [V_W-1:0] v,
  output logic [V_W-1:0] nextRow,
  output logic           fetch,
  output logic           nextLine,
  output logic           visible,
  output logic           hsyncNow,
  output logic           vsyncNow,
  output logic           frameOrigin
);

  assign nextRow = (int'(v) == V_TOTAL - 1) ? '0 : v + V_W'(1);

  // Mid-line fetch two clocks ahead of each 16-pixel group except the first.
  assign fetch = (h[3:0] == 4'd14) && (int'(h) < H_ACTIVE - 16) && (int'(v) < V_ACTIVE);

  // First word of the coming line is fetched two clocks before the line wraps.
  assign nextLine = (int'(h) == H_TOTAL - 2) && (int'(nextRow) < V_ACTIVE);

  assign visible     = (int'(h) < H_ACTIVE) && (int'(v) < V_ACTIVE);
  assign frameOrigin = (h == '0) && (v == '0);
  assign hsyncNow    = syncLevel((int'(h) >= H_ACTIVE + H_FRONT) &&
                                 (int'(h) <  H_ACTIVE + H_FRONT + H_SYNC), SYNC_POL);
  assign vsyncNow    = syncLevel((int'(v) >= V_ACTIVE + V_FRONT) &&
                                 (int'(v) <  V_ACTIVE + V_FRONT + V_SYNC), SYNC_POL);

  // Free-running raster position; reset parks it two clocks before pixel (0,0)
  // so the first fetch of the frame is issued immediately after release.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h <= H_W'(H_TOTAL - 2);
      v <= V_W'(V_TOTAL - 1);
    end else if (int'(h) == H_TOTAL - 1) begin
      h <= '0;
      v <= nextRow;
    end else begin
      h <= h + H_W'(1);
    end
  end

endmodule

// File: rtl/hack_screen_scanner.sv
// Scan-out engine for the Hack screen: issues one word read per 16 pixels,
// captures the returned word and shifts it out LSB-first with sync/blanking.
module hack_screen_scanner
  import hack_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [15:0]       rd_data,
  output logic              pixel,
  output logic              active,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_start
);

  localparam int H_TOTAL        = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL        = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_W            = $clog2(H_TOTAL);
  localparam int V_W            = $clog2(V_TOTAL);
  localparam int WORDS_PER_LINE = H_ACTIVE / 16;

  logic [H_W-1:0] h;
  logic [V_W-1:0] v;
  logic [V_W-1:0] nextRow;
  logic           fetch;
  logic           nextLine;
  logic           visible;
  logic           hsyncNow;
  logic           vsyncNow;
  logic           frameOrigin;

  logic           rdPending;
  logic [15:0]    wordBuf;
  logic [14:0]    shiftReg;
  logic           wordStart;
  int             rowIdx;
  int             wordIdx;

  hack_scan_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .SYNC_POL(SYNC_POL)
  ) timing (
    .clock(clock), .reset(reset), .h(h), .v(v), .nextRow(nextRow),
    .fetch(fetch), .nextLine(nextLine), .visible(visible),
    .hsyncNow(hsyncNow), .vsyncNow(vsyncNow), .frameOrigin(frameOrigin)
  );

  // The line-wrap fetch addresses word 0 of the coming row; a mid-line fetch
  // addresses the group that starts two clocks later on the current row.
  assign rowIdx  = nextLine ? int'(nextRow) : int'(v);
  assign wordIdx = nextLine ? 0 : (int'(h) + 2) / 16;
  assign rd_addr = ADDR_W'(rowIdx * WORDS_PER_LINE + wordIdx);
  assign rd_en   = !reset && (fetch || nextLine);

  assign wordStart = (h[3:0] == 4'd0);

  // Capture the returned word only in the cycle after a request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdPending <= 1'b0;
      wordBuf   <= '0;
    end else begin
      rdPending <= rd_en;
      if (rdPending) wordBuf <= rd_data;
    end
  end

  // Serialiser: a group boundary reloads the upper 15 bits, otherwise drain LSB-first.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shiftReg <= '0;
    end else if (wordStart) begin
      shiftReg <= wordBuf[15:1];
    end else begin
      shiftReg <= shiftReg >> 1;
    end
  end

  // Output registers: every output lags the counter state by exactly one clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pixel       <= 1'b0;
      active      <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else begin
      pixel       <= visible && (wordStart ? wordBuf[0] : shiftReg[0]);
      active      <= visible;
      hsync       <= hsyncNow;
      vsync       <= vsyncNow;
      frame_start <= frameOrigin;
    end
  end

endmodule

// File: doc/hack_screen_scanner.md
Name: hack_screen_scanner

Overview:
- Raster scan-out engine: the read side of the Hack memory-mapped screen, which the CPU writes through Memory addresses 0x4000–0x5FFF.
- Generates h/v timing and issues one word read per 16 pixels to the screen RAM's second (read) port.
- Serialises each word LSB-first into a 1-bit pixel stream with sync and blanking.
- One pixel per clock; the memory must present read data one cycle after the request.

Parameters:
- H_ACTIVE, 512: visible pixels per line; multiple of 16.
- H_FRONT, 16: front-porch clocks.
- H_SYNC, 64: hsync pulse clocks.
- H_BACK, 48: back-porch clocks. H_TOTAL = sum of the four H values, ≥ H_ACTIVE+2.
- V_ACTIVE, 256: visible lines.
- V_FRONT, 3: front-porch lines.
- V_SYNC, 4: vsync pulse lines.
- V_BACK, 21: back-porch lines. V_TOTAL = sum of the four V values.
- ADDR_W, 13: read address width.
- SYNC_POL, 1: asserted level of hsync/vsync.

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high.
- rd_en  out  1  read request to screen RAM.
- rd_addr  out  ADDR_W  word address = v*(H_ACTIVE/16) + w.
- rd_data  in  16  word; must be valid the cycle after rd_en.
- pixel  out  1  pixel value (1 = black in Hack); 0 when blanked.
- active  out  1  high while pixel is visible.
- hsync  out  1  SYNC_POL while the horizontal counter is in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC).
- vsync  out  1  SYNC_POL while the vertical counter is in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC).
- frame_start  out  1  one-cycle pulse coincident with pixel (0,0).

Behaviour:
- Counters: h runs 0..H_TOTAL-1; v runs 0..V_TOTAL-1. h wraps to 0 and v increments on h = H_TOTAL-1. v wraps to 0 after V_TOTAL-1.
- Reset (async, any time, including mid-line or mid-fetch):
  - h = H_TOTAL-2, v = V_TOTAL-1.
  - Word buffer and shift register cleared.
  - Outputs: pixel = 0, active = 0, hsync/vsync = !SYNC_POL, frame_start = 0.
  - rd_en = 0 while reset is asserted.
- rd_en / rd_addr are a combinational decode of (h,v). rd_en is high iff:
  - v < V_ACTIVE and h = 16w-2 for w = 1..H_ACTIVE/16-1; address = v*(H_ACTIVE/16)+w; or
  - h = H_TOTAL-2 and the next line nv = (v+1) mod V_TOTAL satisfies nv < V_ACTIVE; address = nv*(H_ACTIVE/16).
- No other reads occur. Exactly V_ACTIVE*H_ACTIVE/16 reads per frame (8192 at defaults).
- Data path:
  - rd_data is captured into the word buffer at the edge ending the cycle after rd_en (h = 16w-1).
  - At the edge ending h = 16w, bit 0 of the buffer goes to the pixel register and buffer>>1 is loaded into the shift register.
  - At the edges ending the following 15 cycles, the shift register drains LSB-first.
- Output alignment:
  - pixel, active, hsync, vsync and frame_start are all registered.
  - They reflect counter state (h,v) in the cycle after the counters hold (h,v); uniform latency of 1.
  - Pixel (16w,v) therefore appears 3 cycles after the rd_en for word w.
- After reset release:
  - Cycle 0: rd_en = 1, rd_addr = 0.
  - Cycle 1: rd_data consumed.
  - Cycle 3: pixel(0,0) with frame_start = 1.
- Blanking: pixel = 0 whenever active = 0. The shift register content is ignored there.
- rd_data is sampled only in the cycle after rd_en; its value at any other time has no effect.
- Widths: rd_addr is computed modulo 2^ADDR_W. The configuration must satisfy V_ACTIVE*H_ACTIVE/16 ≤ 2^ADDR_W.

Decomposition:
- Shared package hack_pkg:
  - SCREEN_BASE = 16'h4000, KBD_ADDR = 16'h6000.
  - Default timing constants; SCREEN_WORDS = 8192.
- Sub-module hack_scan_timing:
  - Owns the h/v counters, reset preset, and sync/active decode.
  - Exports h, v, fetch strobe and next-line flag.
- hack_screen_scanner adds the address generation, word buffer, shift register and output registers.

Test Plan:
- Small config H_ACTIVE=32, H_FRONT=2, H_SYNC=2, H_BACK=2, V_ACTIVE=2, V_FRONT=1, V_SYNC=1, V_BACK=1. Release reset, memory model returns word 16'h0001 at addr 0 -> rd_en with addr 0 in cycle 0; cycle 3 has pixel = 1, active = 1, frame_start = 1; cycles 4–18 have pixel = 0.
- Same config, memory word = address+16'h8000 -> read addresses in order 0,1,2,3 and 0 again next frame, each exactly once per frame. Bit 15 of every word appears as the 16th pixel of its group.
- Same config -> hsync asserted for 2 clocks per line, starting 34 clocks after the line's first active pixel; vsync asserted for one whole line (38 clocks); active low and pixel = 0 through all blanking.
- Default config, all words 16'hFFFF -> exactly 8192 rd_en pulses between consecutive frame_start pulses, which are 640*284 = 181760 clocks apart; 131072 pixel = 1 cycles per frame.
- Assert reset mid-line (h = 20, v = 1) for 1.5 clocks, asynchronously -> outputs go to their reset values before the next edge; rd_en = 0 while reset is asserted; after release, the cycle 0 / cycle 3 sequence of scenario 1 repeats exactly.
- Drive garbage on rd_data in cycles where the previous cycle had no rd_en -> pixel stream is identical to a run with rd_data held at 0 in those cycles.
